// File: rtl/jam_pkg.sv
// Shared constants and types for the JAM permutation scheduler.
package jam_pkg;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned SW = 10;

    typedef logic [N-1:0][IW-1:0] perm_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation; index 0 is the most significant digit.
module jam_next_perm #(
    parameter int unsigned N  = jam_pkg::N,
    parameter int unsigned IW = jam_pkg::IW
) (
    input  logic [N*IW-1:0] perm,
    output logic [N*IW-1:0] next_perm,
    output logic            is_last
);

    int unsigned        piv;
    int unsigned        swp;
    logic [N*IW-1:0]    swapped;

    always_comb begin
        is_last = 1'b1;
        piv     = 0;
        for (int unsigned k = 0; k + 1 < N; k++) begin
            if (perm[k*IW +: IW] < perm[(k+1)*IW +: IW]) begin
                is_last = 1'b0;
                piv     = k;
            end
        end

        swp = piv;
        for (int unsigned k = 0; k < N; k++) begin
            if ((k > piv) && (perm[k*IW +: IW] > perm[piv*IW +: IW])) begin
                swp = k;
            end
        end

        swapped                 = perm;
        swapped[piv*IW +: IW]   = perm[swp*IW +: IW];
        swapped[swp*IW +: IW]   = perm[piv*IW +: IW];

        // Suffix after the pivot is descending; reversing it yields the smallest tail.
        next_perm = swapped;
        for (int unsigned k = 0; k < N; k++) begin
            if (k > piv) begin
                next_perm[k*IW +: IW] = swapped[(N + piv - k)*IW +: IW];
            end
        end
    end

endmodule

// File: rtl/jam_perm_sched.sv
// Sweeps all N! worker-to-job permutations to an external cost evaluator
// and folds the returned costs into a running minimum and tie count.
module jam_perm_sched #(
    parameter int unsigned N       = jam_pkg::N,
    parameter int unsigned IW      = jam_pkg::IW,
    parameter int unsigned SW      = jam_pkg::SW,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              perm_valid,
    input  logic              perm_ready,
    output logic [N*IW-1:0]   perm,
    input  logic              res_valid,
    input  logic [SW-1:0]     res_cost,
    output logic              busy,
    output logic              Valid,
    output logic [SW-1:0]     MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [CNT_W-1:0]  issued,
    output logic              err
);

    import jam_pkg::state_t;
    import jam_pkg::IDLE;
    import jam_pkg::ISSUE;
    import jam_pkg::DRAIN;
    import jam_pkg::DONE;

    localparam int unsigned PW = N * IW;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    function automatic logic [PW-1:0] identity();
        logic [PW-1:0] p;
        p = '0;
        for (int unsigned k = 0; k < N; k++) p[k*IW +: IW] = IW'(k);
        return p;
    endfunction

    localparam logic [PW-1:0] IDENT = identity();

    state_t          state;
    state_t          state_nxt;
    logic [OW-1:0]   outst;
    logic [PW-1:0]   nxt;
    logic            is_last;
    logic            hs;
    logic            acc;
    logic            bad;
    logic            init;

    jam_next_perm #(.N(N), .IW(IW)) u_next (
        .perm      (perm),
        .next_perm (nxt),
        .is_last   (is_last)
    );

    assign hs   = perm_valid & perm_ready;
    assign acc  = res_valid & (outst != '0) & (state != IDLE);
    assign bad  = res_valid & (outst == '0) & (state != IDLE);
    assign init = start & ((state == IDLE) | (state == DONE));

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (hs && is_last) state_nxt = DRAIN;
            DRAIN:   if (outst == '0) state_nxt = DONE;
            DONE:    if (start) state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; the window check uses last cycle's count so a return frees a slot next cycle
    always_comb begin
        perm_valid = 1'b0;
        busy       = 1'b0;
        Valid      = 1'b0;
        case (state)
            ISSUE: begin
                perm_valid = (outst < OW'(MAX_OUT));
                busy       = 1'b1;
            end
            DRAIN:   busy  = 1'b1;
            DONE:    Valid = 1'b1;
            default: ;
        endcase
    end

    // Permutation, window counter and result fold
    always_ff @(posedge CLK) begin
        if (!RST) begin
            perm       <= IDENT;
            outst      <= '0;
            issued     <= '0;
            MinCost    <= '1;
            MatchCount <= '0;
            err        <= 1'b0;
        end else begin
            outst <= outst + OW'(hs) - OW'(acc);
            if (init) begin
                perm       <= IDENT;
                issued     <= '0;
                MinCost    <= '1;
                MatchCount <= '0;
                err        <= 1'b0;
            end else begin
                if (hs) begin
                    issued <= issued + CNT_W'(1);
                    if (!is_last) perm <= nxt;
                end
                if (acc) begin
                    if (res_cost < MinCost) begin
                        MinCost    <= res_cost;
                        MatchCount <= CNT_W'(1);
                    end else if ((res_cost == MinCost) && (MatchCount != '1)) begin
                        MatchCount <= MatchCount + CNT_W'(1);
                    end
                end
                if (bad) err <= 1'b1;
            end
        end
    end

endmodule
